// File: rtl/ppm_decoder.sv
// 4-PPM frame receiver: SOF lock, four 2-bit symbols, EOF check.
// Emits one byte with a valid strobe, or an error strobe on any timing fault.
module ppm_decoder #(
    parameter int SLOT = 16,
    parameter int TOL  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Din,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int L    = $clog2(SLOT);
    localparam int TW   = $clog2(44 * SLOT + 1);
    localparam int CW   = $clog2(2 * SLOT + 2);

    localparam logic [TW-1:0] SOF2_LO = TW'(5 * SLOT - TOL);
    localparam logic [TW-1:0] SOF2_HI = TW'(5 * SLOT + TOL);
    localparam logic [TW-1:0] EOF_LO  = TW'(42 * SLOT - TOL);
    localparam logic [TW-1:0] EOF_HI  = TW'(42 * SLOT + TOL);
    localparam logic [TW-1:0] T_END   = TW'(44 * SLOT);
    localparam logic [CW-1:0] C_HALF  = CW'(SLOT / 2);
    localparam logic [CW-1:0] C_STUCK = CW'(2 * SLOT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF2,
        S_DATA,
        S_EOF,
        S_DONE,
        S_ERR,
        S_WAIT
    } state_t;

    state_t         r_state;
    state_t         w_state_n;
    logic           r_s1;
    logic           r_ds;
    logic           r_ds_d;
    logic [CW-1:0]  r_lowcnt;
    logic [CW-1:0]  w_cnt;
    logic [TW-1:0]  r_t;
    logic [TW-1:0]  w_t;
    logic [TW-1:0]  w_wend;
    logic [1:0]     r_k;
    logic [1:0]     w_k_n;
    logic           r_got;
    logic           w_got_n;
    logic           r_pend;
    logic           w_pend_n;
    logic [1:0]     r_p;
    logic [1:0]     w_p_n;
    logic [1:0]     w_p;
    logic [7:0]     r_data;
    logic [7:0]     w_data_n;
    logic [7:0]     r_dout;
    logic           r_valid;
    logic           r_err;
    logic           r_busy;
    logic           w_fall;
    logic           w_rise;
    logic           w_qual;
    logic           w_glitch;
    logic           w_stuck;
    logic           w_bound;
    logic           w_prewin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= 1'b1;
            r_ds   <= 1'b1;
            r_ds_d <= 1'b1;
        end else begin
            r_s1   <= Din;
            r_ds   <= r_s1;
            r_ds_d <= r_ds;
        end
    end

    assign w_fall = r_ds_d & ~r_ds;
    assign w_rise = ~r_ds_d & r_ds;

    // Low-run length including the edge cycle; saturates one past the stuck limit
    always_comb begin
        w_cnt = '0;
        if (w_fall) begin
            w_cnt = CW'(1);
        end else if (!r_ds) begin
            w_cnt = (r_lowcnt == C_STUCK) ? r_lowcnt : r_lowcnt + CW'(1);
        end
    end

    assign w_qual   = (w_cnt == C_HALF);
    assign w_glitch = w_rise && (r_lowcnt < C_HALF);
    assign w_stuck  = (w_cnt == C_STUCK);

    assign w_t      = (r_state == S_IDLE && w_fall) ? '0 : r_t;
    assign w_p      = w_t[L+2:L+1];
    assign w_wend   = TW'({1'b0, r_k} + 3'd2) << (L + 3);
    assign w_bound  = (w_t == w_wend);
    assign w_prewin = (w_t[TW-1:L+3] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_k_n     = r_k;
        w_got_n   = r_got;
        w_pend_n  = r_pend;
        w_p_n     = r_p;
        w_data_n  = r_data;
        unique case (r_state)
            S_IDLE: begin
                w_k_n    = '0;
                w_got_n  = 1'b0;
                w_pend_n = 1'b0;
                w_data_n = '0;
                if (w_qual) begin
                    w_state_n = S_SOF2;
                end
            end
            S_SOF2: begin
                if (w_glitch || w_stuck) begin
                    w_state_n = S_ERR;
                end else if (w_fall) begin
                    if (w_t >= SOF2_LO && w_t <= SOF2_HI) begin
                        w_pend_n = 1'b1;
                    end else begin
                        w_state_n = S_ERR;
                    end
                end else if (w_qual && r_pend) begin
                    w_pend_n  = 1'b0;
                    w_state_n = S_DATA;
                end else if (!r_pend && w_t > SOF2_HI) begin
                    w_state_n = S_ERR;
                end
            end
            S_DATA: begin
                if (w_glitch || w_stuck) begin
                    w_state_n = S_ERR;
                end else if (w_bound && !r_got) begin
                    w_state_n = S_ERR;
                end else if (w_bound && r_k == 2'd3) begin
                    w_got_n   = 1'b0;
                    w_pend_n  = 1'b0;
                    w_state_n = w_fall ? S_ERR : S_EOF;
                end else begin
                    if (w_bound) begin
                        w_k_n    = r_k + 2'd1;
                        w_got_n  = 1'b0;
                        w_pend_n = 1'b0;
                    end
                    // A boundary edge opens the next window rather than repeating this one
                    if (w_fall) begin
                        if (w_prewin || (!w_bound && (r_got || r_pend))) begin
                            w_state_n = S_ERR;
                        end else begin
                            w_pend_n = 1'b1;
                            w_p_n    = w_p;
                        end
                    end else if (w_qual && r_pend) begin
                        w_got_n  = 1'b1;
                        w_pend_n = 1'b0;
                        w_data_n[{r_k, 1'b0} +: 2] = {r_p[0], r_p[1]};
                    end
                end
            end
            S_EOF: begin
                if (w_glitch || w_stuck) begin
                    w_state_n = S_ERR;
                end else if (w_fall) begin
                    if (!r_pend && w_t >= EOF_LO && w_t <= EOF_HI) begin
                        w_pend_n = 1'b1;
                    end else begin
                        w_state_n = S_ERR;
                    end
                end else if (w_qual && r_pend) begin
                    w_state_n = S_DONE;
                end else if (w_t >= T_END) begin
                    w_state_n = S_ERR;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            S_ERR, S_WAIT: begin
                w_state_n = r_ds ? S_IDLE : S_WAIT;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lowcnt <= '0;
            r_t      <= '0;
            r_k      <= '0;
            r_got    <= 1'b0;
            r_pend   <= 1'b0;
            r_p      <= '0;
            r_data   <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_lowcnt <= w_cnt;
            r_t      <= w_t + TW'(1);
            r_k      <= w_k_n;
            r_got    <= w_got_n;
            r_pend   <= w_pend_n;
            r_p      <= w_p_n;
            r_data   <= w_data_n;
            r_valid  <= (w_state_n == S_DONE);
            r_err    <= (w_state_n == S_ERR);
            r_busy   <= (w_state_n inside {S_SOF2, S_DATA, S_EOF});
            if (w_state_n == S_DONE) begin
                r_dout <= r_data;
            end
        end
    end

    assign data_out   = r_dout;
    assign data_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = r_busy;

endmodule
